// File: rtl/imem_loader.sv
// imem_loader
//   Receives an instruction image over a byte stream and writes it into the
//   instruction memory one 32-bit word at a time. The CPU core is held in
//   reset for the whole session and is released only after the checksum
//   matches.
//
//   Stream: LEN_LO, LEN_HI (word count N, little-endian), 4N payload bytes
//   (little-endian within each word), then one checksum byte. The checksum
//   is the XOR of the payload bytes only.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse; begins a session from IDLE, DONE or ERR
//   in_byte    stream byte
//   in_valid   in_byte is valid
//   in_ready   loader accepts a byte this cycle
//   mem_we     one-cycle memory write strobe
//   mem_addr   word address of the write (ADDR_W bits)
//   mem_wdata  instruction word to write
//   busy       a session is in progress
//   done       last session finished with a good checksum
//   error      last session failed (bad length or bad checksum)
//   core_hold  holds the CPU core in reset; low only in DONE
//
// Word counters are compared against the 16-bit length, so ADDR_W must be
// 16 or less.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              core_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic              xfer;
  logic              start_ok;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_cnt;   // words written so far; reaches DEPTH
  logic [7:0]        csum;
  logic [23:0]       wbuf;       // first three bytes of the word in flight
  logic [16:0]       len_in;
  logic              last_word;

  assign xfer     = in_valid && in_ready;
  assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign len_in   = {1'b0, in_byte, len_lo};
  // The word whose 4th byte is arriving is the last one of the image.
  assign last_word = (17'(word_cnt) + 17'd1) == {1'b0, len};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    core_hold = 1'b1;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) begin
          if (len_in == 17'd0)            state_nxt = S_CSUM;
          else if (len_in > 17'(DEPTH))   state_nxt = S_ERR;
          else                            state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && byte_cnt == 2'd3 && last_word) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (xfer) state_nxt = (in_byte == csum) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase

    case (state)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
      end
      S_ERR: error = 1'b1;
      default: ;
    endcase
  end

  // Session counters, checksum and the registered memory write port.
  // Resetting byte_cnt is what discards a partially assembled word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo    <= '0;
      len       <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        csum     <= '0;
      end
      if (xfer) begin
        case (state)
          S_LEN_LO: len_lo <= in_byte;
          S_LEN_HI: len    <= {in_byte, len_lo};
          S_DATA: begin
            csum     <= csum ^ in_byte;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_cnt[ADDR_W-1:0];
              mem_wdata <= {in_byte, wbuf};
              word_cnt  <= word_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Byte assembly buffer; its contents are meaningless until byte_cnt says so.
  always_ff @(posedge clk) begin
    if (xfer && state == S_DATA) begin
      case (byte_cnt)
        2'd0: wbuf[7:0]   <= in_byte;
        2'd1: wbuf[15:8]  <= in_byte;
        2'd2: wbuf[23:16] <= in_byte;
        default: ;
      endcase
    end
  end

endmodule
